// File: rtl/pulse_width_decoder_if.sv
// Output word handshake between the pulse-width decoder and its consumer.
// The decoder drives data_out/valid_out through the master modport; the consumer returns ready_in.
interface pulse_width_decoder_if;
    logic [7:0] data_out;
    logic       valid_out;
    logic       ready_in;

    modport master (
        output data_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/pulse_width_decoder.sv
// Decodes pulse-width-coded frames (long low sync, short/long high pulses) into 8-bit words.
// Define PULSE_WIDTH_DECODER_PARITY_EN to require a trailing even-parity pulse per word.
module pulse_width_decoder #(
    parameter int unsigned SHORT_MIN = 20,
    parameter int unsigned SHORT_MAX = 40,
    parameter int unsigned LONG_MIN  = 60,
    parameter int unsigned LONG_MAX  = 90,
    parameter int unsigned GAP_MAX   = 50,
    parameter int unsigned SYNC_LOW  = 200
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         signal_in,
    input  logic [31:0]                  tally_in,
    pulse_width_decoder_if.master        word_if,
    output logic                         error_out,
    output logic                         overflow_out,
    output logic                         busy_out
);

`ifdef PULSE_WIDTH_DECODER_PARITY_EN
    localparam int unsigned CntW    = 4;
    localparam int unsigned ShiftW  = 8;
    localparam int unsigned LastBit = 8;
`else
    localparam int unsigned CntW    = 3;
    localparam int unsigned ShiftW  = 7;
    localparam int unsigned LastBit = 7;
`endif

    localparam logic [31:0] TimeoutTally = 32'(SYNC_LOW - 1);

    typedef enum logic [0:0] {StIdle, StRx} state_e;

    state_e            state_q, state_d;
    logic              level_q;
    logic              armed_q, armed_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ShiftW-1:0] shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              overflow_q, overflow_d;

    logic        run_end;
    logic [31:0] run_len;
    logic        is_short;
    logic        is_long;
    logic        rx_bit;
    logic        word_done;
    logic [7:0]  word;

    assign run_end  = (signal_in != level_q);
    assign run_len  = tally_in + 32'd1;
    assign is_short = (run_len >= SHORT_MIN) && (run_len <= SHORT_MAX);
    assign is_long  = (run_len >= LONG_MIN) && (run_len <= LONG_MAX);
    assign rx_bit   = is_long;

    // Frame decoder: classifies each completed run and assembles words.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        error_d   = 1'b0;
        word_done = 1'b0;
        word      = '0;

        if (run_end && !armed_q) begin
            // The first run after reset has an unknown start, so its length is meaningless.
            armed_d = 1'b1;
        end else if (run_end) begin
            case (state_q)
                StIdle: begin
                    if (!level_q && (run_len >= SYNC_LOW)) begin
                        state_d   = StRx;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
                StRx: begin
                    if (level_q) begin
                        if (is_short || is_long) begin
`ifdef PULSE_WIDTH_DECODER_PARITY_EN
                            if (bit_cnt_q == CntW'(LastBit)) begin
                                bit_cnt_d = '0;
                                if ((^shift_q) == rx_bit) begin
                                    word_done = 1'b1;
                                    word      = shift_q;
                                end else begin
                                    error_d = 1'b1;
                                end
                            end else begin
                                shift_d   = {shift_q[ShiftW-2:0], rx_bit};
                                bit_cnt_d = bit_cnt_q + CntW'(1);
                            end
`else
                            shift_d = {shift_q[ShiftW-2:0], rx_bit};
                            if (bit_cnt_q == CntW'(LastBit)) begin
                                bit_cnt_d = '0;
                                word_done = 1'b1;
                                word      = {shift_q, rx_bit};
                            end else begin
                                bit_cnt_d = bit_cnt_q + CntW'(1);
                            end
`endif
                        end else begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end
                    end else if (run_len > GAP_MAX) begin
                        if (run_len < SYNC_LOW) begin
                            error_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            // Sync seen inside a frame: restart, flagging only a torn word.
                            error_d   = (bit_cnt_q != '0);
                            bit_cnt_d = '0;
                            shift_d   = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if ((state_q == StRx) && (tally_in >= TimeoutTally)) begin
            // A long low with no bits pending is a sync in progress, not a fault.
            if (level_q || (bit_cnt_q != '0)) begin
                error_d = 1'b1;
                state_d = StIdle;
            end
        end
    end

    // One-entry output register; a word completing while the entry is stalled is dropped.
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;

        if (word_done) begin
            if (valid_q && !word_if.ready_in) begin
                overflow_d = 1'b1;
            end else begin
                data_d  = word;
                valid_d = 1'b1;
            end
        end else if (valid_q && word_if.ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            level_q    <= 1'b0;
            armed_q    <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= signal_in;
            armed_q    <= armed_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

    assign word_if.data_out  = data_q;
    assign word_if.valid_out = valid_q;
    assign error_out         = error_q;
    assign overflow_out      = overflow_q;
    assign busy_out          = (state_q == StRx);

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Bench for pulse_width_decoder: models the upstream run-length counter, drives frames,
// and scoreboards accepted words against the words each frame is expected to deliver.
module tb_pulse_width_decoder;

    logic        clk;
    logic        rst;
    logic        sig;
    logic [31:0] tally;
    logic        lvl_tb;
    logic        error_out;
    logic        overflow_out;
    logic        busy_out;
    bit          par_flip;

    pulse_width_decoder_if word_if ();

    pulse_width_decoder dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .signal_in    (sig),
        .tally_in     (tally),
        .word_if      (word_if.master),
        .error_out    (error_out),
        .overflow_out (overflow_out),
        .busy_out     (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream counter: tally is the current run length minus 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tally  <= '0;
            lvl_tb <= 1'b0;
        end else begin
            lvl_tb <= sig;
            tally  <= (sig != lvl_tb) ? 32'd0 : tally + 32'd1;
        end
    end

    int unsigned total;
    int unsigned bad;
    int unsigned err_seen;
    int unsigned ovf_seen;
    logic [7:0]  sb[$];
    logic [7:0]  exp_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted word and counts pulses.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (error_out) err_seen++;
            if (overflow_out) ovf_seen++;
            if (word_if.valid_out && word_if.ready_in) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {24'd0, word_if.data_out}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb.pop_front();
                    check("word", {24'd0, word_if.data_out}, {24'd0, exp_w});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic run(input logic lvl, input int unsigned n);
        sig = lvl;
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits data pulses MSB-first (plus parity when built in), ending on the last high.
    task automatic send_bits(input logic [7:0] d, input int unsigned sh, input int unsigned lg,
                             input int unsigned gap, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (i != 0) run(1'b0, gap);
            run(1'b1, d[7-i] ? lg : sh);
        end
`ifdef PULSE_WIDTH_DECODER_PARITY_EN
        if (nbits == 8) begin
            run(1'b0, gap);
            run(1'b1, ((^d) ^ par_flip) ? lg : sh);
        end
`endif
    endtask

    typedef struct {
        logic [7:0]  data;
        int unsigned sh;
        int unsigned lg;
        int unsigned gap;
        bit          ok;
    } vec_t;

    vec_t        vecs[9];
    int unsigned e0;
    int unsigned o0;

    initial begin
        vecs[0] = '{8'h4D, 30, 70, 30, 1'b1};
        vecs[1] = '{8'hA5, 20, 90, 50, 1'b1};
        vecs[2] = '{8'h3C, 40, 60, 1, 1'b1};
        vecs[3] = '{8'h00, 30, 70, 30, 1'b1};
        vecs[4] = '{8'hFF, 25, 85, 10, 1'b1};
        vecs[5] = '{8'h4D, 50, 70, 30, 1'b0};
        vecs[6] = '{8'h4D, 19, 70, 30, 1'b0};
        vecs[7] = '{8'hB2, 30, 91, 30, 1'b0};
        vecs[8] = '{8'h4D, 30, 70, 51, 1'b0};

        total    = 0;
        bad      = 0;
        err_seen = 0;
        ovf_seen = 0;
        par_flip = 1'b0;
        rst      = 1'b1;
        sig      = 1'b0;
        word_if.ready_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_data", {24'd0, word_if.data_out}, 32'h0);
        check("reset_valid", {31'd0, word_if.valid_out}, 32'h0);
        check("reset_error", {31'd0, error_out}, 32'h0);
        check("reset_overflow", {31'd0, overflow_out}, 32'h0);
        check("reset_busy", {31'd0, busy_out}, 32'h0);

        // Arming run, then the 0x4D latency sequence.
        run(1'b1, 5);
        run(1'b0, 250);
        sb.push_back(8'h4D);
        send_bits(8'h4D, 30, 70, 30, 8);
        run(1'b0, 1);
        check("lat_valid", {31'd0, word_if.valid_out}, 32'h1);
        check("lat_data", {24'd0, word_if.data_out}, 32'h4D);
        check("lat_busy", {31'd0, busy_out}, 32'h1);
        run(1'b0, 1);
        check("lat_valid_drop", {31'd0, word_if.valid_out}, 32'h0);

        // Table of widths, including boundary and out-of-range cases.
        for (int v = 0; v < 9; v++) begin
            e0 = err_seen;
            run(1'b0, 250);
            if (vecs[v].ok) sb.push_back(vecs[v].data);
            send_bits(vecs[v].data, vecs[v].sh, vecs[v].lg, vecs[v].gap, 8);
            run(1'b0, 5);
            check($sformatf("vec%0d_errors", v), err_seen - e0, vecs[v].ok ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_busy", v), {31'd0, busy_out}, {31'd0, vecs[v].ok});
        end

        // Gap of 100 after 3 bits.
        run(1'b0, 250);
        send_bits(8'hA0, 30, 70, 30, 3);
        run(1'b0, 100);
        run(1'b1, 1);
        check("gap_error", {31'd0, error_out}, 32'h1);
        check("gap_busy", {31'd0, busy_out}, 32'h0);
        run(1'b1, 5);

        // Line stuck high after sync: error when tally reaches SYNC_LOW-1.
        run(1'b0, 250);
        run(1'b1, 200);
        check("stuck_hi_early", {31'd0, error_out}, 32'h0);
        check("stuck_hi_busy_before", {31'd0, busy_out}, 32'h1);
        run(1'b1, 1);
        check("stuck_hi_error", {31'd0, error_out}, 32'h1);
        check("stuck_hi_busy", {31'd0, busy_out}, 32'h0);
        run(1'b1, 1);
        check("stuck_hi_pulse_once", {31'd0, error_out}, 32'h0);
        run(1'b1, 98);

        // Line stuck low with bits pending.
        run(1'b0, 250);
        send_bits(8'h80, 30, 70, 30, 2);
        run(1'b0, 200);
        check("stuck_lo_early", {31'd0, error_out}, 32'h0);
        run(1'b0, 1);
        check("stuck_lo_error", {31'd0, error_out}, 32'h1);
        check("stuck_lo_busy", {31'd0, busy_out}, 32'h0);

        // Backpressure: second word overflows, third lands with coincident ready.
        word_if.ready_in = 1'b0;
        o0 = ovf_seen;
        run(1'b0, 250);
        sb.push_back(8'hA5);
        send_bits(8'hA5, 30, 70, 30, 8);
        run(1'b0, 250);
        send_bits(8'h3C, 30, 70, 30, 8);
        run(1'b0, 3);
        check("bp_data_kept", {24'd0, word_if.data_out}, 32'hA5);
        check("bp_valid", {31'd0, word_if.valid_out}, 32'h1);
        check("bp_overflow", ovf_seen - o0, 32'd1);
        run(1'b0, 250);
        send_bits(8'h96, 30, 70, 30, 8);
        sb.push_back(8'h96);
        word_if.ready_in = 1'b1;
        run(1'b0, 1);
        check("bp_third_data", {24'd0, word_if.data_out}, 32'h96);
        check("bp_third_valid", {31'd0, word_if.valid_out}, 32'h1);
        run(1'b0, 1);
        check("bp_third_drop", {31'd0, word_if.valid_out}, 32'h0);
        check("bp_overflow_total", ovf_seen - o0, 32'd1);

        // Asynchronous reset mid-frame with a stalled word pending.
        word_if.ready_in = 1'b0;
        run(1'b0, 250);
        send_bits(8'h5A, 30, 70, 30, 8);
        run(1'b0, 250);
        send_bits(8'hF0, 30, 70, 30, 5);
        run(1'b0, 30);
        run(1'b1, 3);
        check("pre_rst_busy", {31'd0, busy_out}, 32'h1);
        check("pre_rst_valid", {31'd0, word_if.valid_out}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rst_data", {24'd0, word_if.data_out}, 32'h0);
        check("rst_valid", {31'd0, word_if.valid_out}, 32'h0);
        check("rst_busy", {31'd0, busy_out}, 32'h0);
        check("rst_error", {31'd0, error_out}, 32'h0);
        check("rst_overflow", {31'd0, overflow_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        word_if.ready_in = 1'b1;
        run(1'b1, 10);
        run(1'b0, 250);
        sb.push_back(8'hFF);
        send_bits(8'hFF, 30, 70, 30, 8);
        run(1'b0, 5);

`ifdef PULSE_WIDTH_DECODER_PARITY_EN
        run(1'b0, 250);
        sb.push_back(8'h4D);
        par_flip = 1'b0;
        send_bits(8'h4D, 30, 70, 30, 8);
        run(1'b0, 3);
        run(1'b0, 250);
        par_flip = 1'b1;
        send_bits(8'h4D, 30, 70, 30, 8);
        run(1'b0, 1);
        check("par_error", {31'd0, error_out}, 32'h1);
        check("par_valid", {31'd0, word_if.valid_out}, 32'h0);
        check("par_busy", {31'd0, busy_out}, 32'h1);
        par_flip = 1'b0;
        run(1'b0, 5);
`endif

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
